// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and its datapath/memories.
// The master is the controller; the slave is the datapath and memory side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        br_taken;

    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        reg_we;
    logic [2:0]  imm_type;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic        retire;

    modport master (
        input  instr, imem_ack, dmem_ack, br_taken,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we,
               imm_type, alu_a_sel, alu_b_sel, wb_sel, illegal, retire
    );

    modport slave (
        output instr, imem_ack, dmem_ack, br_taken,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we,
               imm_type, alu_a_sel, alu_b_sel, wb_sel, illegal, retire
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch, decode, execute, memory, writeback,
// with memory-wait timeout and illegal-opcode trapping.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OPIMM   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } opclass_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_U = 3'd2;
    localparam logic [2:0] IMM_S = 3'd3;
    localparam logic [2:0] IMM_B = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    opclass_e         cls_q, cls_d;
    opclass_e         decCls;
    opclass_e         activeCls;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reqEn_q;
    logic             illegal_q;
    logic             cntRun;

    logic             imemReq;
    logic             dmemReq;
    logic             dmemWe;
    logic             irWe;
    logic             pcWe;
    logic             pcSel;
    logic             regWe;
    logic [1:0]       wbSel;
    logic             retire;
    logic [2:0]       clsImm;
    logic [1:0]       clsASel;
    logic             clsBSel;
    logic             selValid;
    logic             unusedInstr;

    assign unusedInstr = ^bus.instr[31:7];

    function automatic opclass_e classify(input logic [6:0] opc);
        opclass_e c;
        c = CLS_ILLEGAL;
        unique case (opc)
            OPC_OP:     c = CLS_OP;
            OPC_OPIMM:  c = CLS_OPIMM;
            OPC_LOAD:   c = CLS_LOAD;
            OPC_STORE:  c = CLS_STORE;
            OPC_BRANCH: c = CLS_BRANCH;
            OPC_JAL:    c = CLS_JAL;
            OPC_JALR:   c = CLS_JALR;
            OPC_LUI:    c = CLS_LUI;
            OPC_AUIPC:  c = CLS_AUIPC;
            default:    c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    // During DECODE the class comes straight from IR; afterwards from the latched copy.
    always_comb begin
        decCls    = classify(bus.instr[6:0]);
        activeCls = (state_q == DECODE) ? decCls : cls_q;
    end

    always_comb begin
        clsImm  = IMM_R;
        clsASel = ASEL_RS1;
        clsBSel = 1'b0;
        case (activeCls)
            CLS_OP: begin
                clsImm  = IMM_R;
                clsASel = ASEL_RS1;
                clsBSel = 1'b0;
            end
            CLS_OPIMM, CLS_LOAD, CLS_JALR: begin
                clsImm  = IMM_I;
                clsASel = ASEL_RS1;
                clsBSel = 1'b1;
            end
            CLS_LUI: begin
                clsImm  = IMM_U;
                clsASel = ASEL_ZERO;
                clsBSel = 1'b1;
            end
            CLS_AUIPC: begin
                clsImm  = IMM_U;
                clsASel = ASEL_PC;
                clsBSel = 1'b1;
            end
            CLS_STORE: begin
                clsImm  = IMM_S;
                clsASel = ASEL_RS1;
                clsBSel = 1'b1;
            end
            CLS_BRANCH: begin
                clsImm  = IMM_B;
                clsASel = ASEL_PC;
                clsBSel = 1'b1;
            end
            CLS_JAL: begin
                clsImm  = IMM_J;
                clsASel = ASEL_PC;
                clsBSel = 1'b1;
            end
            default: begin
                clsImm  = IMM_R;
                clsASel = ASEL_RS1;
                clsBSel = 1'b0;
            end
        endcase
    end

    assign selValid = (state_q == DECODE) || (state_q == EXEC) ||
                      (state_q == MEM)    || (state_q == WB);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cntRun  = 1'b0;
        imemReq = 1'b0;
        dmemReq = 1'b0;
        dmemWe  = 1'b0;
        irWe    = 1'b0;
        pcWe    = 1'b0;
        pcSel   = 1'b0;
        regWe   = 1'b0;
        wbSel   = WB_ALU;
        retire  = 1'b0;

        case (state_q)
            FETCH: begin
                // The first cycle after reset keeps the request low so a stale ack is discarded.
                if (reqEn_q) begin
                    imemReq = 1'b1;
                    cntRun  = 1'b1;
                    if (bus.imem_ack) begin
                        irWe    = 1'b1;
                        state_d = DECODE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = TRAP;
                    end
                end
            end
            DECODE: begin
                cls_d   = decCls;
                state_d = (decCls == CLS_ILLEGAL) ? TRAP : EXEC;
            end
            EXEC: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    CLS_BRANCH: begin
                        pcWe    = 1'b1;
                        pcSel   = bus.br_taken;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                dmemReq = 1'b1;
                dmemWe  = (cls_q == CLS_STORE);
                cntRun  = 1'b1;
                if (bus.dmem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        pcWe    = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = TRAP;
                end
            end
            WB: begin
                regWe   = 1'b1;
                pcWe    = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
                case (cls_q)
                    CLS_JAL, CLS_JALR: begin
                        wbSel = WB_PC4;
                        pcSel = 1'b1;
                    end
                    CLS_LOAD: wbSel = WB_MEM;
                    default:  wbSel = WB_ALU;
                endcase
            end
            TRAP: state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cntRun && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cls_q     <= CLS_ILLEGAL;
            cnt_q     <= '0;
            reqEn_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            reqEn_q   <= 1'b1;
            illegal_q <= illegal_q | (state_d == TRAP);
        end
    end

    assign bus.imem_req  = imemReq;
    assign bus.dmem_req  = dmemReq;
    assign bus.dmem_we   = dmemWe;
    assign bus.ir_we     = irWe;
    assign bus.pc_we     = pcWe;
    assign bus.pc_sel    = pcSel;
    assign bus.reg_we    = regWe;
    assign bus.wb_sel    = wbSel;
    assign bus.retire    = retire;
    assign bus.illegal   = illegal_q;
    assign bus.imm_type  = selValid ? clsImm  : IMM_R;
    assign bus.alu_a_sel = selValid ? clsASel : ASEL_RS1;
    assign bus.alu_b_sel = selValid ? clsBSel : 1'b0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-computed per-cycle output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 3;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic       pc_sel;
        logic       reg_we;
        logic [2:0] imm_type;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       retire;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    outs_t expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;
    bit    monActive = 1'b0;

    // Argument order: imem_req dmem_req dmem_we ir_we pc_we pc_sel reg_we imm a b wb illegal retire
    function automatic outs_t o(input logic imemReq, dmemReq, dmemWe, irWe, pcWe, pcSel, regWe,
                                input logic [2:0] imm, input logic [1:0] a, input logic b,
                                input logic [1:0] wb, input logic ill, input logic ret);
        outs_t v;
        v.imem_req  = imemReq;
        v.dmem_req  = dmemReq;
        v.dmem_we   = dmemWe;
        v.ir_we     = irWe;
        v.pc_we     = pcWe;
        v.pc_sel    = pcSel;
        v.reg_we    = regWe;
        v.imm_type  = imm;
        v.alu_a_sel = a;
        v.alu_b_sel = b;
        v.wb_sel    = wb;
        v.illegal   = ill;
        v.retire    = ret;
        return v;
    endfunction

    function automatic outs_t sampleOutputs();
        outs_t v;
        v.imem_req  = bus.imem_req;
        v.dmem_req  = bus.dmem_req;
        v.dmem_we   = bus.dmem_we;
        v.ir_we     = bus.ir_we;
        v.pc_we     = bus.pc_we;
        v.pc_sel    = bus.pc_sel;
        v.reg_we    = bus.reg_we;
        v.imm_type  = bus.imm_type;
        v.alu_a_sel = bus.alu_a_sel;
        v.alu_b_sel = bus.alu_b_sel;
        v.wb_sel    = bus.wb_sel;
        v.illegal   = bus.illegal;
        v.retire    = bus.retire;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (fields imem dmem we ir pcwe pcsel regwe imm a b wb ill ret)",
                     tag, act, exp);
        end
    endtask

    // One clock of stimulus plus the outputs expected during that same cycle.
    task automatic applyStimulus(input string tag, input logic rstN, input logic [31:0] ins,
                                 input logic iAck, input logic dAck, input logic br,
                                 input outs_t exp);
        @(posedge clk);
        #1;
        rst_n        = rstN;
        bus.instr    = ins;
        bus.imem_ack = iAck;
        bus.dmem_ack = dAck;
        bus.br_taken = br;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        monActive = 1'b1;
    endtask

    task automatic doFetch(input string tag, input logic [31:0] ins, input int waits);
        for (int i = 0; i < waits; i++)
            applyStimulus({tag, "_fwait"}, 1'b1, ins, 1'b0, 1'b0, 1'b0, o(1,0,0,0,0,0,0, 3'd0,2'd0,1'b0,2'd0,1'b0,1'b0));
        applyStimulus({tag, "_fack"}, 1'b1, ins, 1'b1, 1'b0, 1'b0, o(1,0,0,1,0,0,0, 3'd0,2'd0,1'b0,2'd0,1'b0,1'b0));
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (monActive) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got DUT cycle with no expected entry, required queued entry");
                end else begin
                    checkOutput(tagQ.pop_front(), sampleOutputs(), expQ.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        outs_t idleV;
        outs_t trapV;
        idleV = o(0,0,0,0,0,0,0, 3'd0,2'd0,1'b0,2'd0,1'b0,1'b0);
        trapV = o(0,0,0,0,0,0,0, 3'd0,2'd0,1'b0,2'd0,1'b1,1'b0);

        bus.instr    = 32'h0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.br_taken = 1'b0;
        repeat (2) @(posedge clk);

        // First cycle out of reset: no request yet, a stale ack must not load IR.
        applyStimulus("rst_lateack", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, idleV);

        doFetch("addi", 32'h00500093, 2);
        applyStimulus("addi_dec",  1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("addi_exec", 1'b1, 32'h00500093, 1'b0, 1'b1, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("addi_wb",   1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, o(0,0,0,0,1,0,1, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b1));

        doFetch("lw", 32'h0000A103, 0);
        applyStimulus("lw_dec",  1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lw_exec", 1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lw_mem0", 1'b1, 32'h0000A103, 1'b1, 1'b0, 1'b0, o(0,1,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lw_mem1", 1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,1,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lw_mem2", 1'b1, 32'h0000A103, 1'b0, 1'b1, 1'b0, o(0,1,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lw_wb",   1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,0,0,0,1,0,1, 3'd1,2'd0,1'b1,2'd1,1'b0,1'b1));

        doFetch("sw", 32'h00112023, 0);
        applyStimulus("sw_dec",  1'b1, 32'h00112023, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd3,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("sw_exec", 1'b1, 32'h00112023, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd3,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("sw_mem",  1'b1, 32'h00112023, 1'b0, 1'b1, 1'b0, o(0,1,1,0,1,0,0, 3'd3,2'd0,1'b1,2'd0,1'b0,1'b1));

        doFetch("beqT", 32'hFE000EE3, 0);
        applyStimulus("beqT_dec",  1'b1, 32'hFE000EE3, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd4,2'd1,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("beqT_exec", 1'b1, 32'hFE000EE3, 1'b0, 1'b0, 1'b1, o(0,0,0,0,1,1,0, 3'd4,2'd1,1'b1,2'd0,1'b0,1'b1));

        doFetch("beqN", 32'hFE000EE3, 0);
        applyStimulus("beqN_dec",  1'b1, 32'hFE000EE3, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd4,2'd1,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("beqN_exec", 1'b1, 32'hFE000EE3, 1'b0, 1'b0, 1'b0, o(0,0,0,0,1,0,0, 3'd4,2'd1,1'b1,2'd0,1'b0,1'b1));

        doFetch("jal", 32'h008000EF, 0);
        applyStimulus("jal_dec",  1'b1, 32'h008000EF, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd5,2'd1,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("jal_exec", 1'b1, 32'h008000EF, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd5,2'd1,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("jal_wb",   1'b1, 32'h008000EF, 1'b0, 1'b0, 1'b0, o(0,0,0,0,1,1,1, 3'd5,2'd1,1'b1,2'd2,1'b0,1'b1));

        doFetch("add", 32'h002081B3, 0);
        applyStimulus("add_dec",  1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd0,2'd0,1'b0,2'd0,1'b0,1'b0));
        applyStimulus("add_exec", 1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd0,2'd0,1'b0,2'd0,1'b0,1'b0));
        applyStimulus("add_wb",   1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, o(0,0,0,0,1,0,1, 3'd0,2'd0,1'b0,2'd0,1'b0,1'b1));

        doFetch("lui", 32'h123450B7, 0);
        applyStimulus("lui_dec",  1'b1, 32'h123450B7, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd2,2'd2,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lui_exec", 1'b1, 32'h123450B7, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd2,2'd2,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lui_wb",   1'b1, 32'h123450B7, 1'b0, 1'b0, 1'b0, o(0,0,0,0,1,0,1, 3'd2,2'd2,1'b1,2'd0,1'b0,1'b1));

        doFetch("auipc", 32'h00000097, 0);
        applyStimulus("auipc_dec",  1'b1, 32'h00000097, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd2,2'd1,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("auipc_exec", 1'b1, 32'h00000097, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd2,2'd1,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("auipc_wb",   1'b1, 32'h00000097, 1'b0, 1'b0, 1'b0, o(0,0,0,0,1,0,1, 3'd2,2'd1,1'b1,2'd0,1'b0,1'b1));

        doFetch("jalr", 32'h000080E7, 0);
        applyStimulus("jalr_dec",  1'b1, 32'h000080E7, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("jalr_exec", 1'b1, 32'h000080E7, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("jalr_wb",   1'b1, 32'h000080E7, 1'b0, 1'b0, 1'b0, o(0,0,0,0,1,1,1, 3'd1,2'd0,1'b1,2'd2,1'b0,1'b1));

        // Illegal opcode, then acks while trapped, then a one-edge reset.
        doFetch("ill", 32'h0000007F, 0);
        applyStimulus("ill_dec",   1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0, idleV);
        applyStimulus("ill_trap0", 1'b1, 32'h0000007F, 1'b1, 1'b1, 1'b0, trapV);
        applyStimulus("ill_trap1", 1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0, trapV);
        applyStimulus("ill_rstlo", 1'b0, 32'h0000007F, 1'b0, 1'b0, 1'b0, trapV);
        applyStimulus("ill_rstd",  1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0, idleV);

        // Fetch timeout: four waiting FETCH cycles then TRAP.
        for (int i = 0; i < 4; i++)
            applyStimulus("fto_wait", 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, o(1,0,0,0,0,0,0, 3'd0,2'd0,1'b0,2'd0,1'b0,1'b0));
        applyStimulus("fto_trap0", 1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, trapV);
        applyStimulus("fto_rstlo", 1'b0, 32'h00500093, 1'b0, 1'b0, 1'b0, trapV);
        applyStimulus("fto_rstd",  1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, idleV);

        // Reset in the middle of a load drops dmem_req; a late ack afterwards is ignored.
        doFetch("lwr", 32'h0000A103, 0);
        applyStimulus("lwr_dec",   1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lwr_exec",  1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lwr_rstlo", 1'b0, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,1,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("lwr_drop",  1'b1, 32'h0000A103, 1'b1, 1'b1, 1'b0, idleV);

        // Data memory timeout: four MEM cycles without ack then TRAP.
        doFetch("dto", 32'h0000A103, 0);
        applyStimulus("dto_dec",  1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("dto_exec", 1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        for (int i = 0; i < 4; i++)
            applyStimulus("dto_mem", 1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,1,0,0,0,0,0, 3'd1,2'd0,1'b1,2'd0,1'b0,1'b0));
        applyStimulus("dto_trap", 1'b1, 32'h0000A103, 1'b0, 1'b1, 1'b0, trapV);

        @(posedge clk);
        #1;
        monActive = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d entries left, required 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
